// File: rtl/line_memory_responder_pkg.sv
// Shared constants and FSM state type for the line memory responder.
package mem_if_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned BEATS      = LINE_BYTES * 8 / DATA_W;
    localparam int unsigned BEAT_W     = 3;
    localparam int unsigned LAT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        WR_WAIT,
        WR_BEAT
    } state_t;

endpackage

// File: rtl/line_memory_responder_if.sv
// Cache-to-memory bundle: line refill read channel plus dirty-line write-back channel.
interface line_memory_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);

    logic                            ram_req;
    logic [ADDR_W-1:0]               ram_address;
    logic                            ram_ready;
    logic [DATA_W-1:0]               ram_in;
    logic [mem_if_pkg::BEAT_W-1:0]   ram_beat;
    logic                            wb_req;
    logic [ADDR_W-1:0]               wb_address;
    logic [DATA_W-1:0]               wb_data;
    logic                            wb_ack;
    logic [mem_if_pkg::BEAT_W-1:0]   wb_beat;
    logic                            busy;

    // Cache side
    modport master (
        output ram_req, ram_address, wb_req, wb_address, wb_data,
        input  ram_ready, ram_in, ram_beat, wb_ack, wb_beat, busy
    );

    // Memory side
    modport slave (
        input  ram_req, ram_address, wb_req, wb_address, wb_data,
        output ram_ready, ram_in, ram_beat, wb_ack, wb_beat, busy
    );

endinterface

// File: rtl/line_memory_responder_mem_array.sv
// Backing store: MEM_WORDS x DATA_W synchronous RAM, one write port, one registered read port.
module mem_array #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned DATA_W    = 64
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
    output logic [DATA_W-1:0]            o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/line_memory_responder.sv
// Memory-side responder: 8-beat line refills after READ_LAT, write-backs acked after WRITE_LAT.
// Optional macro CRITICAL_WORD_FIRST_EN starts refills at the requested word and wraps in the line.
module line_memory_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned READ_LAT   = 4,
    parameter int unsigned WRITE_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    line_memory_responder_if.slave bus
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned LINE_W   = AW - BEAT_W;
    localparam int unsigned LINE_LSB = $clog2(LINE_BYTES);

    localparam logic [LAT_W-1:0]  RD_LOAD   = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0]  WR_LOAD   = LAT_W'(WRITE_LAT - 1);
    localparam logic [LAT_W-1:0]  LAST_CNT  = LAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_rd_lat
            $error("READ_LAT must be in 1..15");
        end
        if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_wr_lat
            $error("WRITE_LAT must be in 1..15");
        end
        if ((MEM_WORDS & (MEM_WORDS - 1)) != 0 || MEM_WORDS < BEATS) begin : g_bad_depth
            $error("MEM_WORDS must be a power of two holding at least one line");
        end
        if (LINE_BYTES * 8 / DATA_W != BEATS) begin : g_bad_line
            $error("LINE_BYTES and DATA_W must give an 8-beat line");
        end
    endgenerate

    state_t              r_state, w_state_nxt;
    logic [LAT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [LINE_W-1:0]   r_rd_line, w_rd_line_nxt;
    logic [LINE_W-1:0]   r_wb_line, w_wb_line_nxt;
    logic [BEAT_W-1:0]   r_rd_beat, w_rd_beat_nxt;
    logic [BEAT_W-1:0]   r_wb_beat, w_wb_beat_nxt;
    logic                r_rd_armed, w_rd_armed_nxt;
    logic                r_wb_armed, w_wb_armed_nxt;

    logic [LINE_W-1:0]   w_req_line;
    logic [BEAT_W-1:0]   w_req_start;
    logic                w_rd_go;
    logic                w_wb_go;
    logic [AW-1:0]       w_rd_addr;
    logic [AW-1:0]       w_wr_addr;
    logic                w_we;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused;

    // Upper address bits wrap away; low byte-offset bits carry no information.
    assign w_unused    = ^{bus.ram_address, bus.wb_address};
    assign w_req_line  = bus.ram_address[LINE_LSB +: LINE_W];
`ifdef CRITICAL_WORD_FIRST_EN
    assign w_req_start = bus.ram_address[LINE_LSB-1 -: BEAT_W];
`else
    assign w_req_start = '0;
`endif

    assign w_rd_go = bus.ram_req & r_rd_armed;
    assign w_wb_go = bus.wb_req & r_wb_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd_line  <= '0;
            r_wb_line  <= '0;
            r_rd_beat  <= '0;
            r_wb_beat  <= '0;
            r_rd_armed <= 1'b1;
            r_wb_armed <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_line  <= w_rd_line_nxt;
            r_wb_line  <= w_wb_line_nxt;
            r_rd_beat  <= w_rd_beat_nxt;
            r_wb_beat  <= w_wb_beat_nxt;
            r_rd_armed <= w_rd_armed_nxt;
            r_wb_armed <= w_wb_armed_nxt;
        end
    end

    // Read address runs one beat ahead of ram_beat so the registered RAM output lines up with ram_ready.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rd_line_nxt  = r_rd_line;
        w_wb_line_nxt  = r_wb_line;
        w_rd_beat_nxt  = r_rd_beat;
        w_wb_beat_nxt  = r_wb_beat;
        w_rd_armed_nxt = r_rd_armed | ~bus.ram_req;
        w_wb_armed_nxt = r_wb_armed | ~bus.wb_req;
        w_rd_addr      = {r_rd_line, r_rd_beat};

        unique case (r_state)
            IDLE: begin
                w_rd_addr = {w_req_line, w_req_start};
                // Write-back wins a tie so a same-line refill sees the new data.
                if (w_wb_go) begin
                    w_wb_armed_nxt = 1'b0;
                    w_wb_line_nxt  = bus.wb_address[LINE_LSB +: LINE_W];
                    w_wb_beat_nxt  = '0;
                    w_cnt_nxt      = WR_LOAD;
                    if (WRITE_LAT == 1) begin
                        w_state_nxt = WR_BEAT;
                    end else begin
                        w_state_nxt = WR_WAIT;
                    end
                end else if (w_rd_go) begin
                    w_rd_armed_nxt = 1'b0;
                    w_rd_line_nxt  = w_req_line;
                    w_rd_beat_nxt  = w_req_start;
                    if (READ_LAT == 1) begin
                        w_cnt_nxt   = LAST_CNT;
                        w_state_nxt = RD_BEAT;
                    end else begin
                        w_cnt_nxt   = RD_LOAD;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_cnt == LAT_W'(1)) begin
                    w_cnt_nxt   = LAST_CNT;
                    w_state_nxt = RD_BEAT;
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            RD_BEAT: begin
                w_rd_addr     = {r_rd_line, BEAT_W'(r_rd_beat + BEAT_W'(1))};
                w_rd_beat_nxt = r_rd_beat + BEAT_W'(1);
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            WR_WAIT: begin
                if (r_cnt == LAT_W'(1)) begin
                    w_state_nxt = WR_BEAT;
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            WR_BEAT: begin
                w_wb_beat_nxt = r_wb_beat + BEAT_W'(1);
                if (r_wb_beat == LAST_BEAT) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_we      = (r_state == WR_BEAT);
    assign w_wr_addr = {r_wb_line, r_wb_beat};

    mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_wr_addr),
        .i_wdata (bus.wb_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    assign bus.ram_ready = (r_state == RD_BEAT);
    assign bus.ram_in    = bus.ram_ready ? w_rdata : '0;
    assign bus.ram_beat  = r_rd_beat;
    assign bus.wb_ack    = (r_state == WR_BEAT);
    assign bus.wb_beat   = r_wb_beat;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: table vectors, hand corner sequences, randomized bursts vs a line-level model.
module tb_line_memory_responder;

    localparam int unsigned RL   = 4;
    localparam int unsigned WL   = 2;
    localparam int unsigned MEMW = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_memory_responder_if #(.ADDR_W(32), .DATA_W(64)) u_if ();

    line_memory_responder #(
        .DATA_W     (64),
        .ADDR_W     (32),
        .LINE_BYTES (64),
        .MEM_WORDS  (MEMW),
        .READ_LAT   (RL),
        .WRITE_LAT  (WL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    logic [63:0] wline [8];
    assign u_if.wb_data = wline[u_if.wb_beat];

    logic [63:0] model_mem [MEMW];
    int          e_rb   [int];
    logic [63:0] e_rd   [int];
    int          e_wb   [int];
    bit          e_busy [int];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] wa;
        logic [31:0] ra;
        logic [63:0] base;
        int          start_cwf;
    } vec_t;

    function automatic int base_of(logic [31:0] a);
        return int'(((a >> 6) * 8) % MEMW);
    endfunction

    function automatic int start_of(logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return int'((a >> 3) & 32'd7);
`else
        return (a == 32'hFFFF_FFFF) ? 0 : 0;
`endif
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".ram_ready"}, 64'(u_if.ram_ready), 64'd0);
        chk({nm, ".ram_in"},    u_if.ram_in,         64'd0);
        chk({nm, ".ram_beat"},  64'(u_if.ram_beat),  64'd0);
        chk({nm, ".wb_ack"},    64'(u_if.wb_ack),    64'd0);
        chk({nm, ".wb_beat"},   64'(u_if.wb_beat),   64'd0);
        chk({nm, ".busy"},      64'(u_if.busy),      64'd0);
    endtask

    task automatic clear_exp();
        e_rb.delete();
        e_rd.delete();
        e_wb.delete();
        e_busy.delete();
    endtask

    task automatic step();
        bit er, ew, eb;
        @(posedge clk);
        cyc++;
        #1;
        er = e_rb.exists(cyc);
        ew = e_wb.exists(cyc);
        eb = e_busy.exists(cyc);
        chk("ram_ready", 64'(u_if.ram_ready), 64'(er));
        if (er) begin
            chk("ram_beat", 64'(u_if.ram_beat), 64'(e_rb[cyc]));
            chk("ram_in", u_if.ram_in, e_rd[cyc]);
        end
        chk("wb_ack", 64'(u_if.wb_ack), 64'(ew));
        if (ew) chk("wb_beat", 64'(u_if.wb_beat), 64'(e_wb[cyc]));
        chk("busy", 64'(u_if.busy), 64'(eb));
    endtask

    task automatic run_until(int c);
        while (cyc < c) step();
    endtask

    // Write accepted in cycle t: acks t+WL..t+WL+7 in order 0..7, memory updated.
    task automatic sched_write(int t, logic [31:0] wa);
        int w0 = base_of(wa);
        for (int k = 0; k < 8; k++) begin
            e_wb[t + WL + k] = k;
            model_mem[w0 + k] = wline[k];
        end
        for (int c = t + 1; c <= t + WL + 7; c++) e_busy[c] = 1'b1;
    endtask

    task automatic sched_read(int t, logic [31:0] ra);
        int w0 = base_of(ra);
        int s  = start_of(ra);
        for (int i = 0; i < 8; i++) begin
            e_rb[t + RL + i] = (s + i) % 8;
            e_rd[t + RL + i] = model_mem[w0 + ((s + i) % 8)];
        end
        for (int c = t + 1; c <= t + RL + 7; c++) e_busy[c] = 1'b1;
    endtask

    task automatic sched_read_exp(int t, int s, logic [63:0] base);
        for (int i = 0; i < 8; i++) begin
            e_rb[t + RL + i] = (s + i) % 8;
            e_rd[t + RL + i] = base + 64'((s + i) % 8);
        end
        for (int c = t + 1; c <= t + RL + 7; c++) e_busy[c] = 1'b1;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 8; k++) wline[k] = {$urandom, $urandom};
    endtask

    // One transaction starting now (DUT idle, both requests armed); wline must already be filled.
    task automatic txn(bit w, bit r, logic [31:0] wa, logic [31:0] ra, int hw, int hr);
        int t0, tr, tend;
        t0 = cyc;
        if (w) begin
            u_if.wb_req = 1'b1;
            u_if.wb_address = wa;
            sched_write(t0, wa);
        end
        tr = w ? t0 + WL + 8 : t0;
        if (r) begin
            u_if.ram_req = 1'b1;
            u_if.ram_address = ra;
            sched_read(tr, ra);
        end
        tend = r ? tr + RL + 8 : t0 + WL + 8;
        do begin
            step();
            if (cyc >= t0 + hw) u_if.wb_req = 1'b0;
            if (cyc > t0) u_if.wb_address = $urandom;
            if (cyc >= tr + hr) u_if.ram_req = 1'b0;
            if (cyc > tr) u_if.ram_address = $urandom;
        end while (cyc < tend || u_if.wb_req || u_if.ram_req);
        step();
    endtask

    function automatic logic [31:0] rand_addr(int line);
        return ($urandom & 32'hFFFF_8000) | (32'(line) << 6) | ($urandom & 32'h3F);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   t0, tr, s;

        vt[0] = '{32'h0000_0040, 32'h0000_0040, 64'h1000, 0};
        vt[1] = '{32'h0000_0040, 32'h0000_0058, 64'h1000, 3};
        vt[2] = '{32'h0000_0080, 32'h0000_00B8, 64'h2000, 7};
        vt[3] = '{32'hFFFF_FFC0, 32'h0000_7FF0, 64'h3000, 6};
        vt[4] = '{32'h0000_01C5, 32'h0001_01C8, 64'h4000, 1};
        vt[5] = '{32'h0000_013F, 32'h0000_0120, 64'h5000, 4};

        u_if.ram_req = 1'b0;
        u_if.ram_address = '0;
        u_if.wb_req = 1'b0;
        u_if.wb_address = '0;
        for (int k = 0; k < 8; k++) wline[k] = '0;

        #1;
        chk_zero("reset");
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Table: write a line, then refill it (possibly through an aliased address).
        foreach (vt[i]) begin
            for (int k = 0; k < 8; k++) wline[k] = vt[i].base + 64'(k);
            t0 = cyc;
            u_if.wb_req = 1'b1;
            u_if.wb_address = vt[i].wa;
            sched_write(t0, vt[i].wa);
            step();
            u_if.wb_req = 1'b0;
            run_until(t0 + WL + 8);
            tr = cyc;
`ifdef CRITICAL_WORD_FIRST_EN
            s = vt[i].start_cwf;
`else
            s = 0;
`endif
            u_if.ram_req = 1'b1;
            u_if.ram_address = vt[i].ra;
            sched_read_exp(tr, s, vt[i].base);
            step();
            u_if.ram_req = 1'b0;
            run_until(tr + RL + 9);
        end

        // Simultaneous same-line requests: write-back first, refill sees the new data.
        for (int k = 0; k < 8; k++) wline[k] = 64'hAA00 + 64'(k);
        txn(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0080, 1, 1);

        // Request held 5 cycles past its last beat, dropped one cycle, raised again.
        txn(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1, RL + 13);
        txn(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1, 1);

        // Reset during read beat 3, then a full refill of the same line.
        t0 = cyc;
        u_if.ram_req = 1'b1;
        u_if.ram_address = 32'h0000_0040;
        sched_read(t0, 32'h0000_0040);
        step();
        u_if.ram_req = 1'b0;
        run_until(t0 + RL + 3);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        clear_exp();
        step();
        step();
        rst = 1'b0;
        step();
        step();
        txn(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1, 1);

        // Randomized traffic over 16 lines with aliased upper address bits.
        for (int l = 0; l < 16; l++) begin
            fill_rand();
            txn(1'b1, 1'b0, rand_addr(l), 32'h0, 1, 1);
        end
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 2);
            fill_rand();
            txn(kind != 1, kind != 0,
                rand_addr($urandom_range(0, 15)), rand_addr($urandom_range(0, 15)),
                $urandom_range(1, 16), $urandom_range(1, 16));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
